// File: rtl/mc_datapath.sv
// mc_datapath: multicycle CPU datapath with a shared instruction/data memory port.
// Architectural registers (PC, IR, MDR, A, B, ALUOut) advance one micro-step per clock
// under the control of an external multicycle controller; there is no internal FSM.
module mc_datapath #(
    parameter int unsigned n       = 16,
    parameter int unsigned regbits = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         pcwrite,
    input  logic         branch,
    input  logic         iord,
    input  logic         irwrite,
    input  logic         regdst,
    input  logic         memtoreg,
    input  logic         regwrite,
    input  logic         alusrca,
    input  logic [1:0]   alusrcb,
    input  logic [1:0]   pcsrc,
    input  logic         signexten,
    input  logic [2:0]   alucontrol,
    input  logic [n-1:0] readdata,
    output logic [2:0]   op,
    output logic         zero,
    output logic [n-1:0] adr,
    output logic [n-1:0] writedata,
    output logic [n-1:0] pc
);

    // Immediate width: whatever is left of the word after op, rs and rt.
    localparam int          iw    = int'(n) - 3 - 2 * int'(regbits);
    localparam int unsigned nregs = 1 << regbits;

    // rd sits at the top of the immediate field, so the immediate must be able to hold it.
    if (iw < int'(regbits)) begin : g_bad_params
        $error("mc_datapath: immediate field narrower than a register index");
    end

    // ALU operation encodings
    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;
    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluSub = 3'b110;
    localparam logic [2:0] AluSlt = 3'b111;

    // Architectural state
    logic [n-1:0] pc_q;
    logic [n-1:0] ir_q;
    logic [n-1:0] mdr_q;
    logic [n-1:0] a_q;
    logic [n-1:0] b_q;
    logic [n-1:0] aluout_q;
    logic [n-1:0] rf [nregs];

    // Decoded instruction fields
    logic [regbits-1:0] rs;
    logic [regbits-1:0] rt;
    logic [regbits-1:0] rd;
    logic [iw-1:0]      imm;

    // Datapath nets
    logic [n-1:0]       imm_ext;
    logic [n-1:0]       imm_sh;
    logic [n-1:0]       rf_rd1;
    logic [n-1:0]       rf_rd2;
    logic [n-1:0]       src_a;
    logic [n-1:0]       src_b;
    logic [n-1:0]       alu_result;
    logic [n-1:0]       pc_next;
    logic [n-1:0]       jump_target;
    logic [n-1:0]       wb_result;
    logic [regbits-1:0] writereg;
    logic               pcen;

    assign rs  = ir_q[n-4 -: regbits];
    assign rt  = ir_q[n-4-int'(regbits) -: regbits];
    assign rd  = ir_q[iw-1 -: regbits];
    assign imm = ir_q[iw-1:0];

    // Immediate extension; the shifted form drops the MSB of the extended value.
    always_comb begin
        imm_ext = signexten ? {{(n - iw){imm[iw-1]}}, imm} : {{(n - iw){1'b0}}, imm};
        imm_sh  = {imm_ext[n-2:0], 1'b0};
    end

    // Combinational register file reads; r0 is hardwired to zero.
    always_comb begin
        rf_rd1 = (rs == '0) ? '0 : rf[rs];
        rf_rd2 = (rt == '0) ? '0 : rf[rt];
    end

    // ALU operand selection
    always_comb begin
        src_a = alusrca ? a_q : pc_q;
        src_b = '0;
        unique case (alusrcb)
            2'b00:   src_b = b_q;
            2'b01:   src_b = {{(n - 2){1'b0}}, 2'b10};
            2'b10:   src_b = imm_ext;
            2'b11:   src_b = imm_sh;
            default: src_b = '0;
        endcase
    end

    // ALU: modulo-2^n arithmetic, signed set-less-than, undefined codes give zero.
    always_comb begin
        alu_result = '0;
        case (alucontrol)
            AluAnd:  alu_result = src_a & src_b;
            AluOr:   alu_result = src_a | src_b;
            AluAdd:  alu_result = src_a + src_b;
            AluSub:  alu_result = src_a - src_b;
            AluSlt:  alu_result = {{(n - 1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            default: alu_result = '0;
        endcase
    end

    assign zero = (alu_result == '0);

    // Jump keeps the top three bits of the already-incremented PC.
    assign jump_target = {pc_q[n-1:n-3], ir_q[n-4:0]};

    // Next-PC selection and enable
    always_comb begin
        pc_next = pc_q;
        unique case (pcsrc)
            2'b00:   pc_next = alu_result;
            2'b01:   pc_next = aluout_q;
            2'b10:   pc_next = jump_target;
            2'b11:   pc_next = pc_q;
            default: pc_next = pc_q;
        endcase
        pcen = pcwrite | (branch & zero);
    end

    // Writeback index and data selection
    always_comb begin
        writereg  = regdst ? rd : rt;
        wb_result = memtoreg ? mdr_q : aluout_q;
    end

    // PC register: updated only when enabled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= '0;
        end else if (pcen) begin
            pc_q <= pc_next;
        end
    end

    // Instruction register: latched only on fetch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_q <= '0;
        end else if (irwrite) begin
            ir_q <= readdata;
        end
    end

    // Free-running pipeline registers between micro-steps
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mdr_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
        end else begin
            mdr_q    <= readdata;
            a_q      <= rf_rd1;
            b_q      <= rf_rd2;
            aluout_q <= alu_result;
        end
    end

    // Register file write; writes to r0 are discarded
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(nregs); i++) begin
                rf[i] <= '0;
            end
        end else if (regwrite && (writereg != '0)) begin
            rf[writereg] <= wb_result;
        end
    end

    // Output assignments
    always_comb begin
        op        = ir_q[n-1:n-3];
        adr       = iord ? aluout_q : pc_q;
        writedata = b_q;
        pc        = pc_q;
    end

endmodule

// File: tb/tb_mc_datapath.sv
// Self-checking bench for mc_datapath: drives micro-step control sequences directly and
// plays the role of memory by supplying readdata each cycle.
module tb_mc_datapath;

    logic        clk = 1'b0;
    logic        reset;

    // 16-bit instance
    logic        pcwrite, branch, iord, irwrite, regdst, memtoreg, regwrite, alusrca, signexten;
    logic [1:0]  alusrcb, pcsrc;
    logic [2:0]  alucontrol;
    logic [15:0] readdata;
    logic [2:0]  op;
    logic        zero;
    logic [15:0] adr, writedata, pc;

    // 32-bit instance
    logic        w_pcwrite, w_branch, w_iord, w_irwrite, w_regdst, w_memtoreg, w_regwrite;
    logic        w_alusrca, w_signexten;
    logic [1:0]  w_alusrcb, w_pcsrc;
    logic [2:0]  w_alucontrol;
    logic [31:0] w_readdata;
    logic [2:0]  w_op;
    logic        w_zero;
    logic [31:0] w_adr, w_writedata, w_pc;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] sb_q[$];
    logic [31:0] exp_v, obs;
    logic [15:0] exp_pc;
    logic [15:0] rv;

    always #5 clk = ~clk;

    mc_datapath #(.n(16), .regbits(3)) dut (
        .clk(clk), .reset(reset), .pcwrite(pcwrite), .branch(branch), .iord(iord),
        .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .signexten(signexten),
        .alucontrol(alucontrol), .readdata(readdata), .op(op), .zero(zero), .adr(adr),
        .writedata(writedata), .pc(pc)
    );

    mc_datapath #(.n(32), .regbits(5)) dut_w (
        .clk(clk), .reset(reset), .pcwrite(w_pcwrite), .branch(w_branch), .iord(w_iord),
        .irwrite(w_irwrite), .regdst(w_regdst), .memtoreg(w_memtoreg), .regwrite(w_regwrite),
        .alusrca(w_alusrca), .alusrcb(w_alusrcb), .pcsrc(w_pcsrc), .signexten(w_signexten),
        .alucontrol(w_alucontrol), .readdata(w_readdata), .op(w_op), .zero(w_zero),
        .adr(w_adr), .writedata(w_writedata), .pc(w_pc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        pcwrite = 0; branch = 0; iord = 0; irwrite = 0; regdst = 0; memtoreg = 0;
        regwrite = 0; alusrca = 0; signexten = 0; alusrcb = 2'b00; pcsrc = 2'b00;
        alucontrol = 3'b000; readdata = '0;
    endtask

    task automatic wclr();
        w_pcwrite = 0; w_branch = 0; w_iord = 0; w_irwrite = 0; w_regdst = 0; w_memtoreg = 0;
        w_regwrite = 0; w_alusrca = 0; w_signexten = 0; w_alusrcb = 2'b00; w_pcsrc = 2'b00;
        w_alucontrol = 3'b000; w_readdata = '0;
    endtask

    // Load IR without touching PC
    task automatic set_ir(input logic [15:0] instr);
        clr(); readdata = instr; irwrite = 1; tick(); clr();
    endtask

    // Put val into rf[idx] through MDR (memtoreg path)
    task automatic load_reg(input logic [2:0] idx, input logic [15:0] val);
        set_ir({3'b000, 3'd0, idx, 7'd0});
        readdata = val; tick();
        regwrite = 1; memtoreg = 1; regdst = 0; tick(); clr();
    endtask

    // Observe rf[idx] via B -> writedata
    task automatic read_reg(input logic [2:0] idx, output logic [15:0] val);
        set_ir({3'b000, 3'd0, idx, 7'd0});
        tick();
        val = writedata;
    endtask

    task automatic fetch(input logic [15:0] instr);
        clr(); readdata = instr; iord = 0; irwrite = 1; alusrca = 0; alusrcb = 2'b01;
        alucontrol = 3'b010; pcsrc = 2'b00; pcwrite = 1;
        tick(); clr();
        exp_pc = exp_pc + 16'd2;
    endtask

    // Move PC to target via r7 -> A -> ALU
    task automatic goto_pc(input logic [15:0] target);
        load_reg(3'd7, target);
        set_ir({3'b000, 3'd7, 3'd0, 7'd0});
        tick();
        alusrca = 1; alusrcb = 2'b00; alucontrol = 3'b010; pcsrc = 2'b00; pcwrite = 1;
        tick(); clr();
        exp_pc = target;
    endtask

    task automatic wtick_ir(input logic [31:0] instr);
        wclr(); w_readdata = instr; w_irwrite = 1; tick(); wclr();
    endtask

    task automatic wload(input logic [4:0] idx, input logic [31:0] val);
        wtick_ir({3'b000, 5'd0, idx, 19'd0});
        w_readdata = val; tick();
        w_regwrite = 1; w_memtoreg = 1; tick(); wclr();
    endtask

    task automatic test_reset();
        reset = 0; clr(); wclr();
        sb_q.push_back(32'h0); sb_q.push_back(32'h0); sb_q.push_back(32'h0);
        sb_q.push_back(32'h0);
        tick(); tick();
        obs = 32'(pc); exp_v = sb_q.pop_front(); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL reset_pc got=%h want=%h", obs, exp_v); end
        obs = 32'(adr); exp_v = sb_q.pop_front(); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL reset_adr got=%h want=%h", obs, exp_v); end
        obs = 32'(writedata); exp_v = sb_q.pop_front(); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL reset_wd got=%h want=%h", obs, exp_v); end
        obs = 32'(op); exp_v = sb_q.pop_front(); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL reset_op got=%h want=%h", obs, exp_v); end
        reset = 1; #1;
        exp_pc = 16'h0;
        sb_q.push_back(32'h0);
        obs = 32'(adr); exp_v = sb_q.pop_front(); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL fetch0_adr got=%h want=%h", obs, exp_v); end
        fetch(16'h0000);
        sb_q.push_back(32'(exp_pc)); sb_q.push_back(32'h0);
        obs = 32'(pc); exp_v = sb_q.pop_front(); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL fetch0_pc got=%h want=%h", obs, exp_v); end
        obs = 32'(op); exp_v = sb_q.pop_front(); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL fetch0_op got=%h want=%h", obs, exp_v); end
    endtask

    task automatic test_add();
        load_reg(3'd1, 16'd5); load_reg(3'd2, 16'd7);
        fetch({3'b000, 3'd1, 3'd2, 3'd3, 4'd0});
        sb_q.push_back(32'(exp_pc)); sb_q.push_back(32'd12);
        alusrcb = 2'b11; alucontrol = 3'b010; tick(); clr();
        alusrca = 1; alusrcb = 2'b00; alucontrol = 3'b010; tick(); clr();
        regdst = 1; memtoreg = 0; regwrite = 1; tick(); clr();
        obs = 32'(pc); exp_v = sb_q.pop_front(); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL add_pc got=%h want=%h", obs, exp_v); end
        read_reg(3'd3, rv);
        obs = 32'(rv); exp_v = sb_q.pop_front(); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL add_rf3 got=%h want=%h", obs, exp_v); end
    endtask

    task automatic test_lw_ext();
        logic [1:0]  srcb [3] = '{2'b10, 2'b10, 2'b11};
        logic        sext [3] = '{1'b0, 1'b1, 1'b1};
        logic [15:0] want [3] = '{16'h007E, 16'hFFFE, 16'hFFFC};
        load_reg(3'd1, 16'h0010);
        fetch({3'b100, 3'd1, 3'd4, 7'd4});
        sb_q.push_back(32'd4); sb_q.push_back(32'h0014); sb_q.push_back(32'hBEEF);
        obs = 32'(op); exp_v = sb_q.pop_front(); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL lw_op got=%h want=%h", obs, exp_v); end
        alusrcb = 2'b11; alucontrol = 3'b010; tick(); clr();
        alusrca = 1; alusrcb = 2'b10; signexten = 1; alucontrol = 3'b010; tick(); clr();
        iord = 1; readdata = 16'hBEEF; #1;
        obs = 32'(adr); exp_v = sb_q.pop_front(); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL lw_adr got=%h want=%h", obs, exp_v); end
        tick(); clr();
        regdst = 0; memtoreg = 1; regwrite = 1; tick(); clr();
        read_reg(3'd4, rv);
        obs = 32'(rv); exp_v = sb_q.pop_front(); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL lw_rf4 got=%h want=%h", obs, exp_v); end
        // Immediate extension variants with A = r0 = 0
        set_ir({3'b000, 3'd0, 3'd0, 7'h7E});
        tick();
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back(32'(want[i]));
            alusrca = 1; alusrcb = srcb[i]; signexten = sext[i]; alucontrol = 3'b010;
            tick(); clr();
            iord = 1; #1;
            obs = 32'(adr); exp_v = sb_q.pop_front(); checks++;
            if (obs !== exp_v) begin
                failures++; $display("FAIL imm_ext[%0d] got=%h want=%h", i, obs, exp_v);
            end
            clr();
        end
    endtask

    task automatic test_branch(input logic [15:0] rb, input logic taken);
        load_reg(3'd1, 16'd3); load_reg(3'd2, rb);
        goto_pc(16'h0008);
        fetch({3'b010, 3'd1, 3'd2, 7'h7E});
        sb_q.push_back(32'(taken)); sb_q.push_back(taken ? 32'h6 : 32'(exp_pc));
        alusrcb = 2'b11; signexten = 1; alucontrol = 3'b010; tick(); clr();
        alusrca = 1; alusrcb = 2'b00; alucontrol = 3'b110; pcsrc = 2'b01; branch = 1; #1;
        obs = 32'(zero); exp_v = sb_q.pop_front(); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL beq_zero got=%h want=%h", obs, exp_v); end
        tick(); clr();
        obs = 32'(pc); exp_v = sb_q.pop_front(); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL beq_pc got=%h want=%h", obs, exp_v); end
        if (taken) exp_pc = 16'h6;
    endtask

    task automatic test_jump_r0();
        goto_pc(16'h2000);
        fetch({3'b011, 13'h0100});
        sb_q.push_back(32'd3); sb_q.push_back(32'h2100); sb_q.push_back(32'h2100);
        sb_q.push_back(32'h0);
        obs = 32'(op); exp_v = sb_q.pop_front(); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL j_op got=%h want=%h", obs, exp_v); end
        pcwrite = 1; pcsrc = 2'b10; tick(); clr();
        obs = 32'(pc); exp_v = sb_q.pop_front(); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL j_pc got=%h want=%h", obs, exp_v); end
        pcwrite = 1; pcsrc = 2'b11; tick(); clr();
        obs = 32'(pc); exp_v = sb_q.pop_front(); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL hold_pc got=%h want=%h", obs, exp_v); end
        exp_pc = 16'h2100;
        load_reg(3'd0, 16'd9);
        read_reg(3'd0, rv);
        obs = 32'(rv); exp_v = sb_q.pop_front(); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL r0 got=%h want=%h", obs, exp_v); end
    endtask

    task automatic test_alu();
        logic [15:0] ta [8] = '{16'hF0F0, 16'hF0F0, 16'h0003, 16'hFFFF,
                                16'h0001, 16'h1234, 16'hFFFF, 16'h8000};
        logic [15:0] tb [8] = '{16'h0FF0, 16'h0FF0, 16'h0005, 16'h0001,
                                16'hFFFF, 16'h5678, 16'h0001, 16'h7FFF};
        logic [2:0]  tc [8] = '{3'b000, 3'b001, 3'b110, 3'b111,
                                3'b111, 3'b011, 3'b010, 3'b111};
        logic [15:0] te [8] = '{16'h00F0, 16'hFFF0, 16'hFFFE, 16'h0001,
                                16'h0000, 16'h0000, 16'h0000, 16'h0001};
        for (int i = 0; i < 8; i++) begin
            load_reg(3'd1, ta[i]); load_reg(3'd2, tb[i]);
            set_ir({3'b000, 3'd1, 3'd2, 7'd0});
            tick();
            sb_q.push_back(32'(te[i] == 16'h0)); sb_q.push_back(32'(te[i]));
            alusrca = 1; alusrcb = 2'b00; alucontrol = tc[i]; #1;
            obs = 32'(zero); exp_v = sb_q.pop_front(); checks++;
            if (obs !== exp_v) begin
                failures++; $display("FAIL alu_zero[%0d] got=%h want=%h", i, obs, exp_v);
            end
            tick(); clr();
            iord = 1; #1;
            obs = 32'(adr); exp_v = sb_q.pop_front(); checks++;
            if (obs !== exp_v) begin
                failures++; $display("FAIL alu_res[%0d] got=%h want=%h", i, obs, exp_v);
            end
            clr();
        end
    endtask

    task automatic test_mid_reset();
        load_reg(3'd1, 16'd5); load_reg(3'd2, 16'd7);
        fetch({3'b000, 3'd1, 3'd2, 3'd6, 4'd0});
        alusrcb = 2'b11; alucontrol = 3'b010; tick(); clr();
        sb_q.push_back(32'h0); sb_q.push_back(32'h0); sb_q.push_back(32'h0);
        alusrca = 1; alusrcb = 2'b00; alucontrol = 3'b010; #2;
        reset = 0; #1;
        obs = 32'(pc); exp_v = sb_q.pop_front(); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL arst_pc got=%h want=%h", obs, exp_v); end
        obs = 32'(op); exp_v = sb_q.pop_front(); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL arst_op got=%h want=%h", obs, exp_v); end
        iord = 1; #1;
        obs = 32'(adr); exp_v = sb_q.pop_front(); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL arst_aluout got=%h want=%h", obs, exp_v); end
        clr(); regdst = 1; regwrite = 1;
        tick(); tick();
        reset = 1; clr(); exp_pc = 16'h0;
        sb_q.push_back(32'h0); sb_q.push_back(32'h0); sb_q.push_back(32'h0);
        read_reg(3'd6, rv);
        obs = 32'(rv); exp_v = sb_q.pop_front(); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL arst_rf6 got=%h want=%h", obs, exp_v); end
        read_reg(3'd1, rv);
        obs = 32'(rv); exp_v = sb_q.pop_front(); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL arst_rf1 got=%h want=%h", obs, exp_v); end
        clr(); #1;
        obs = 32'(adr); exp_v = sb_q.pop_front(); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL arst_fetch_adr got=%h want=%h", obs, exp_v); end
    endtask

    // Same-edge write and read: B sees the old value, the new one a cycle later
    task automatic test_rf_timing();
        sb_q.push_back(32'h0); sb_q.push_back(32'h1234);
        load_reg(3'd3, 16'h1234);
        obs = 32'(writedata); exp_v = sb_q.pop_front(); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL rf_old got=%h want=%h", obs, exp_v); end
        tick();
        obs = 32'(writedata); exp_v = sb_q.pop_front(); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL rf_new got=%h want=%h", obs, exp_v); end
    endtask

    task automatic test_wide();
        logic [31:0] wa [2] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF};
        logic [2:0]  wc [2] = '{3'b010, 3'b111};
        logic [31:0] we [2] = '{32'h8000_0000, 32'h0000_0001};
        for (int i = 0; i < 2; i++) begin
            wload(5'd1, wa[i]); wload(5'd2, 32'h1);
            wtick_ir({3'b000, 5'd1, 5'd2, 19'd0});
            tick();
            sb_q.push_back(32'h1); sb_q.push_back(we[i]);
            obs = w_writedata; exp_v = sb_q.pop_front(); checks++;
            if (obs !== exp_v) begin
                failures++; $display("FAIL wide_b[%0d] got=%h want=%h", i, obs, exp_v);
            end
            w_alusrca = 1; w_alusrcb = 2'b00; w_alucontrol = wc[i]; tick(); wclr();
            w_iord = 1; #1;
            obs = w_adr; exp_v = sb_q.pop_front(); checks++;
            if (obs !== exp_v) begin
                failures++; $display("FAIL wide_res[%0d] got=%h want=%h", i, obs, exp_v);
            end
            wclr();
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_ext();
        test_branch(16'd3, 1'b1);
        test_branch(16'd4, 1'b0);
        test_jump_r0();
        test_alu();
        test_mid_reset();
        test_rf_timing();
        test_wide();
        checks++;
        if (sb_q.size() != 0) begin
            failures++; $display("FAIL scoreboard_leftover got=%0d want=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_datapath.md
Name: mc_datapath

Overview:
- Parametrised multicycle successor to the single-cycle CPU datapath.
- Instructions and data share one memory port.
- State is held in architectural registers (PC, IR, MDR, A, B, ALUOut) and advanced one micro-step per clock under an external multicycle controller.
- Adds PC-relative branches, a selectable sign/zero extend, a hardwired-zero r0 and generic data/register widths.

Parameters:
- n, 16, datapath and instruction width in bits.
- regbits, 3, register index width; register file depth is 2**regbits.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-low reset (0 = reset)
- pcwrite  input  1  unconditional PC update
- branch  input  1  conditional PC update when zero=1
- iord  input  1  adr select: 0 = PC, 1 = ALUOut
- irwrite  input  1  latch readdata into IR
- regdst  input  1  write index: 0 = rt, 1 = rd
- memtoreg  input  1  write data: 0 = ALUOut, 1 = MDR
- regwrite  input  1  register file write enable
- alusrca  input  1  ALU A: 0 = PC, 1 = A register
- alusrcb  input  2  ALU B: 00 = B, 01 = constant 2, 10 = imm, 11 = imm<<1
- pcsrc  input  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = hold PC
- signexten  input  1  1 = sign-extend imm, 0 = zero-extend
- alucontrol  input  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; others yield 0
- readdata  input  n  memory read data
- op  output  3  IR[n-1:n-3], to controller
- zero  output  1  combinational: ALU result == 0
- adr  output  n  memory address
- writedata  output  n  B register, store data
- pc  output  n  current PC

Behaviour:
- IR field layout, with iw = n-3-2*regbits:
  - op = IR[n-1:n-3]
  - rs = next regbits bits
  - rt = next regbits bits
  - rd = IR[iw-1 -: regbits]
  - imm = IR[iw-1:0]
  - n=16, regbits=3 gives rs [12:10], rt [9:7], rd [6:4], imm [6:0].
- Parameter check: iw must be ≥ regbits; elaboration fails otherwise.
- Jump target = {PC[n-1:n-3], IR[n-4:0]}, using the PC value already incremented during fetch.
- Reset (async, reset=0) clears PC, IR, MDR, A, B, ALUOut and all register file entries to 0. Outputs then read pc=0, adr=0 (when iord=0), writedata=0, op=0.
- On every rising edge with reset=1:
  - MDR<=readdata; A<=rf[rs]; B<=rf[rt]; ALUOut<=ALU result (unconditional).
  - IR<=readdata only if irwrite=1.
  - PC<=pcnext only if pcen = pcwrite | (branch & zero).
  - rf[writereg]<=result only if regwrite=1 and writereg≠0.
- r0 reads 0 always; writes to index 0 are discarded.
- Register file reads are combinational. A same-edge write and read of one index gives A/B the old value; the new value appears one cycle later.
- Arithmetic is modulo 2**n with no overflow flag. SLT is signed and returns 1 or 0, zero-extended. SUB is A−B.
- imm<<1 drops the MSB of the extended value.
- Canonical sequences:
  - Fetch: iord=0, irwrite=1, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00, pcwrite=1 → IR=mem[PC], PC+=2.
  - Branch: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, branch=1. ALUOut must hold PC+(imm<<1) from the preceding decode cycle (alusrca=0, alusrcb=11).
- Every control combination is legal; no internal FSM. pcsrc=11 with pcen=1 leaves PC unchanged.
- Reset asserted mid-instruction aborts immediately. The first fetch after release reads address 0.

Test Plan:
- Hold reset=0 two cycles, release → pc=0, adr=0, writedata=0; fetch mem[0]=16'h0000 → IR=0, pc=2.
- Preload rf[1]=5, rf[2]=7; fetch ADD rs=1 rt=2 rd=3; run decode, execute (alusrca=1, alusrcb=00, 010), writeback (regdst=1, memtoreg=0, regwrite=1) → rf[3]=12, pc=2.
- LW: rf[1]=16'h0010, imm=4, signexten=1, iord=1 in memory cycle, mem[16'h0014]=16'hBEEF → adr=16'h0014; rt register = 16'hBEEF after writeback.
- BEQ at pc=8, rf[1]=rf[2]=3, imm=7'h7E (−2) → zero=1, pc=8+2−4=6. Same with rf[2]=4 → zero=0, pc stays 10.
- Jump at pc=16'h2000, IR[12:0]=13'h0100, pcsrc=10, pcwrite=1 → pc=16'h2100. Write 9 to r0 → r0 still reads 0.
- Pull reset low during the execute cycle of an ADD → no register written, PC/IR/ALUOut=0 asynchronously. With n=32, regbits=5, ADD 0x7FFFFFFF+1 → 0x80000000, SLT(−1,1)=1.
